// File: rtl/lsu_mem_sequencer.sv
// lsu_mem_sequencer: splits RV32I loads/stores into aligned-word or big-endian byte beats and returns one extended response (req_* in, resp_* out, mem_* beat port)
module lsu_mem_sequencer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic                     mem_we,
  output logic                     mem_byte_op,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);
  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;
  state_t state;
  logic r_we, word, legal, xfer, sb, sh;
  logic [2:0] r_f3;
  logic [1:0] beat, last, sel;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, acc_nxt, ext;
  logic [DATA_WIDTH-BYTE_WIDTH-1:0] acc;
  always_comb begin
    legal = req_we ? req_funct3 inside {3'b000, 3'b001, 3'b010} : req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    xfer = state == XFER;
    sel = last - beat;
    acc_nxt = word ? mem_rdata : {acc, mem_rdata[BYTE_WIDTH-1:0]};
    sb = !r_f3[2] && acc_nxt[BYTE_WIDTH-1];
    sh = !r_f3[2] && acc_nxt[2*BYTE_WIDTH-1];
    ext = r_f3[1] ? acc_nxt : r_f3[0] ? {{(DATA_WIDTH-2*BYTE_WIDTH){sh}}, acc_nxt[2*BYTE_WIDTH-1:0]} : {{(DATA_WIDTH-BYTE_WIDTH){sb}}, acc_nxt[BYTE_WIDTH-1:0]};
  end
  assign req_ready = state == IDLE && !rst;
  assign mem_we = xfer && r_we && !rst;
  assign mem_byte_op = xfer && !word;
  assign mem_addr = xfer ? r_addr + ADDRESS_WIDTH'(beat) : '0;
  assign mem_wdata = !xfer ? '0 : word ? r_wdata : DATA_WIDTH'(r_wdata[int'(sel)*BYTE_WIDTH +: BYTE_WIDTH]);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat <= '0;
      last <= '0;
      acc <= '0;
      word <= 1'b0;
      r_we <= 1'b0;
      r_f3 <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          r_we <= req_we;
          r_f3 <= req_funct3;
          r_addr <= req_addr;
          r_wdata <= req_wdata;
          word <= req_funct3[1:0] == 2'b10 && req_addr[1:0] == 2'b00;
          last <= req_funct3[1] ? (req_addr[1:0] == 2'b00 ? 2'd0 : 2'd3) : {1'b0, req_funct3[0]};
          beat <= '0;
          acc <= '0;
          state <= legal ? XFER : RESP;
          resp_valid <= !legal;
          resp_err <= !legal;
          resp_rdata <= '0;
        end
        XFER: begin
          acc <= acc_nxt[DATA_WIDTH-BYTE_WIDTH-1:0];
          beat <= beat + 2'd1;
          if (beat == last) begin
            state <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= r_we ? '0 : ext;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// tb_lsu_mem_sequencer: directed scoreboard bench for lsu_mem_sequencer against a big-endian byte memory model
module tb_lsu_mem_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_we = 1'b0;
  logic [2:0] req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic req_ready, resp_valid, resp_err, mem_we, mem_byte_op;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [7:0] m [0:255];
  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int acc_cyc = 0;
  typedef struct {logic [31:0] rdata; logic err; int lat;} exp_t;
  exp_t sb[$];
  logic [65:0] beats[$];
  lsu_mem_sequencer dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_we(mem_we), .mem_byte_op(mem_byte_op),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_byte_op) m[mem_addr[7:0]] = mem_wdata[7:0];
      else begin
        m[mem_addr[7:0]] = mem_wdata[31:24];
        m[mem_addr[7:0] + 8'd1] = mem_wdata[23:16];
        m[mem_addr[7:0] + 8'd2] = mem_wdata[15:8];
        m[mem_addr[7:0] + 8'd3] = mem_wdata[7:0];
      end
    end
  end
  always_comb mem_rdata = mem_byte_op ? {24'h0, m[mem_addr[7:0]]} :
    {m[mem_addr[7:0]], m[mem_addr[7:0] + 8'd1], m[mem_addr[7:0] + 8'd2], m[mem_addr[7:0] + 8'd3]};
  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (mem_we || mem_byte_op || mem_addr != 0) beats.push_back({mem_we, mem_byte_op, mem_addr, mem_wdata});
    if (resp_valid === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_resp", 66'(resp_valid), 66'(0));
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", 66'(resp_rdata), 66'(e.rdata));
        chk("resp_err", 66'(resp_err), 66'(e.err));
        chk("latency", 66'(cyc - acc_cyc), 66'(e.lat));
      end
    end
  end
  task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input logic err, input int n);
    int w;
    beats.delete();
    sb.push_back('{rdata: rd, err: err, lat: n + 1});
    req_valid = 1'b1;
    req_we = we;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    acc_cyc = cyc;
    @(negedge clk);
    #1;
    req_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      chk("resp_timeout", 66'(sb.size()), 66'(0));
      sb.delete();
    end
    @(negedge clk);
    chk("resp_one_cycle", 66'(resp_valid), 66'(0));
    chk("ready_after_resp", 66'(req_ready), 66'(1));
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) m[i] = 8'h00;
    m[0] = 8'h12;
    m[1] = 8'h34;
    m[2] = 8'h56;
    m[3] = 8'h78;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 66'(req_ready), 66'(0));
    chk("rst_resp_valid", 66'(resp_valid), 66'(0));
    chk("rst_resp_err", 66'(resp_err), 66'(0));
    chk("rst_resp_rdata", 66'(resp_rdata), 66'(0));
    chk("rst_mem", {mem_we, mem_byte_op, mem_addr, mem_wdata}, 66'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", 66'(req_ready), 66'(1));
    run(1'b0, 3'b010, 32'h10000, 32'h0, 32'h12345678, 1'b0, 1);
    chk("lw_nbeats", 66'(beats.size()), 66'(1));
    chk("lw_beat0", beats[0], {1'b0, 1'b0, 32'h10000, 32'h0});
    m[3] = 8'h80;
    run(1'b0, 3'b000, 32'h10003, 32'h0, 32'hFFFFFF80, 1'b0, 1);
    chk("lb_beat0", beats[0], {1'b0, 1'b1, 32'h10003, 32'h0});
    run(1'b0, 3'b100, 32'h10003, 32'h0, 32'h00000080, 1'b0, 1);
    run(1'b1, 3'b001, 32'h10001, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    chk("sh_nbeats", 66'(beats.size()), 66'(2));
    chk("sh_beat0", beats[0], {1'b1, 1'b1, 32'h10001, 32'hBE});
    chk("sh_beat1", beats[1], {1'b1, 1'b1, 32'h10002, 32'hEF});
    chk("sh_m1", 66'(m[1]), 66'(8'hBE));
    chk("sh_m2", 66'(m[2]), 66'(8'hEF));
    run(1'b0, 3'b001, 32'h10001, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
    run(1'b0, 3'b101, 32'h10001, 32'h0, 32'h0000BEEF, 1'b0, 2);
    run(1'b1, 3'b010, 32'h10002, 32'hCAFEF00D, 32'h0, 1'b0, 4);
    chk("sw_nbeats", 66'(beats.size()), 66'(4));
    chk("sw_beat3", beats[3], {1'b1, 1'b1, 32'h10005, 32'h0D});
    chk("sw_mem", 66'({m[2], m[3], m[4], m[5]}), 66'(32'hCAFEF00D));
    run(1'b0, 3'b010, 32'h10002, 32'h0, 32'hCAFEF00D, 1'b0, 4);
    run(1'b0, 3'b011, 32'h10000, 32'h0, 32'h0, 1'b1, 0);
    chk("err_no_beats", 66'(beats.size()), 66'(0));
    run(1'b1, 3'b100, 32'h10000, 32'h55555555, 32'h0, 1'b1, 0);
    chk("err_st_no_beats", 66'(beats.size()), 66'(0));
    chk("err_st_mem", 66'({m[0], m[1]}), 66'(16'h12BE));
    run(1'b1, 3'b010, 32'hFFFFFFFF, 32'hA1B2C3D4, 32'h0, 1'b0, 4);
    chk("wrap_beat1", beats[1], {1'b1, 1'b1, 32'h0, 32'hB2});
    chk("wrap_mem", 66'({m[255], m[0], m[1], m[2]}), 66'(32'hA1B2C3D4));
    m[0] = 8'h12;
    m[1] = 8'hBE;
    m[2] = 8'hCA;
    req_valid = 1'b1;
    req_we = 1'b1;
    req_funct3 = 3'b010;
    req_addr = 32'h10001;
    req_wdata = 32'h11223344;
    @(negedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_beat1_addr", 66'(mem_addr), 66'(32'h10002));
    rst = 1'b1;
    #1;
    chk("rst_gates_we", 66'(mem_we), 66'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready", 66'(req_ready), 66'(1));
    chk("rst_mid_m1", 66'(m[1]), 66'(8'h11));
    chk("rst_mid_m2", 66'(m[2]), 66'(8'hCA));
    repeat (4) @(negedge clk);
    chk("rst_mid_no_resp", 66'(sb.size()), 66'(0));
    run(1'b0, 3'b100, 32'h10001, 32'h0, 32'h00000011, 1'b0, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
